// File: rtl/prio_arbiter_rr_if.sv
// Request/grant bundle between N request sources and the prio_arbiter_rr arbiter.
// The master side drives requests and acks; the slave side (arbiter) returns the grant.
interface prio_arbiter_rr_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned CNT_W = 8
);
  logic [N-1:0]     req;
  logic             mode;
  logic             ack;
  logic             valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     gnt_onehot;
  logic [CNT_W-1:0] gnt_cnt;

  modport master (
    output req, mode, ack,
    input  valid, gnt_idx, gnt_onehot, gnt_cnt
  );

  modport slave (
    input  req, mode, ack,
    output valid, gnt_idx, gnt_onehot, gnt_cnt
  );
endinterface

// File: rtl/prio_arbiter_rr.sv
// Registered N-requester arbiter with fixed-priority or round-robin selection.
// A grant is held until acked or withdrawn; acked grants are counted with saturation.
module prio_arbiter_rr #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  prio_arbiter_rr_if.slave   bus
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic [IDX_W-1:0] ack_ptr;
  logic [N-1:0]     masked_req;

  // mode 0: highest set index; mode 1: first set bit walking down from p with wrap.
  function automatic logic [IDX_W-1:0] winner(input logic [N-1:0]     r,
                                               input logic             rr,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] w;
    logic [N-1:0]     sh;
    int unsigned      j;
    w = '0;
    if (!rr) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (r[i]) w = IDX_W'(i);
      end
    end else begin
      // Iterate from the farthest candidate so the nearest to p overwrites last.
      for (int unsigned k = N; k > 0; k--) begin
        j  = (32'(p) + N - (k - 1)) % N;
        sh = r >> j;
        if (sh[0]) w = IDX_W'(j);
      end
    end
    return w;
  endfunction

  always_comb begin
    ack_ptr    = (idx_q == '0) ? IDX_W'(N - 1) : idx_q - IDX_W'(1);
    masked_req = bus.req & ~(N'(1) << idx_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req != '0) begin
          state_d = StGrant;
          idx_d   = winner(bus.req, bus.mode, ptr_q);
        end
      end
      StGrant: begin
        if (bus.ack) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          ptr_d = ack_ptr;
          if (masked_req != '0) begin
            idx_d = winner(masked_req, bus.mode, ack_ptr);
          end else begin
            state_d = StIdle;
          end
        end else if (!bus.req[idx_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    onehot_d = (state_d == StGrant) ? (N'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      ptr_q    <= IDX_W'(N - 1);
      cnt_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
    end
  end

  assign bus.valid      = (state_q == StGrant);
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.gnt_cnt    = cnt_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: directed vector table, reset/saturation sequences and
// randomized traffic against a list-based reference model (two counter widths).
module tb_prio_arbiter_rr;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int CW  = 8;
  localparam int CWS = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic         mode  = 1'b0;
  logic         ack   = 1'b0;

  always #5 clk = ~clk;

  prio_arbiter_rr_if #(.N(N), .IDX_W(IW), .CNT_W(CW))  bus   ();
  prio_arbiter_rr_if #(.N(N), .IDX_W(IW), .CNT_W(CWS)) bus_s ();

  assign bus.req    = req;
  assign bus.mode   = mode;
  assign bus.ack    = ack;
  assign bus_s.req  = req;
  assign bus_s.mode = mode;
  assign bus_s.ack  = ack;

  prio_arbiter_rr #(.N(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  prio_arbiter_rr #(.N(N), .IDX_W(IW), .CNT_W(CWS)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_valid, m_idx, m_ptr, m_cnt, m_cnt_s;

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Build the priority list the rules describe and take the first requester in it.
  function automatic int win(input logic [N-1:0] r, input logic md, input int p);
    int order[$];
    if (!md) begin
      for (int i = N - 1; i >= 0; i--) order.push_back(i);
    end else begin
      for (int k = 0; k < N; k++) order.push_back((p - k + N) % N);
    end
    foreach (order[j]) if (r[order[j]]) return order[j];
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_idx = 0; m_ptr = N - 1; m_cnt = 0; m_cnt_s = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] masked;
    if (m_valid == 0) begin
      if (req != 0) begin
        m_valid = 1;
        m_idx   = win(req, mode, m_ptr);
      end
    end else if (ack) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_cnt_s < (1 << CWS) - 1) m_cnt_s++;
      m_ptr  = (m_idx == 0) ? N - 1 : m_idx - 1;
      masked = req;
      masked[m_idx] = 1'b0;
      if (masked != 0) m_idx = win(masked, mode, m_ptr);
      else m_valid = 0;
    end else if (!req[m_idx]) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    cmp({tag, "_valid"}, int'(bus.valid), m_valid);
    cmp({tag, "_onehot"}, int'(bus.gnt_onehot), m_valid ? (1 << m_idx) : 0);
    cmp({tag, "_cnt"}, int'(bus.gnt_cnt), m_cnt);
    if (m_valid != 0) cmp({tag, "_idx"}, int'(bus.gnt_idx), m_idx);
    cmp({tag, "_s_valid"}, int'(bus_s.valid), m_valid);
    cmp({tag, "_s_cnt"}, int'(bus_s.gnt_cnt), m_cnt_s);
    if (m_valid != 0) cmp({tag, "_s_idx"}, int'(bus_s.gnt_idx), m_idx);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_valid"}, int'(bus.valid), 0);
    cmp({tag, "_idx"}, int'(bus.gnt_idx), 0);
    cmp({tag, "_onehot"}, int'(bus.gnt_onehot), 0);
    cmp({tag, "_cnt"}, int'(bus.gnt_cnt), 0);
    cmp({tag, "_s_cnt"}, int'(bus_s.gnt_cnt), 0);
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    logic         mode;
    logic         ack;
    int           ev;
    int           eidx;
    int           eoh;
    int           ecnt;
    string        name;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 1, 0, 4'b0001, 0, "t1_first"};
    vecs[1]  = '{1'b0, 4'b1010, 1'b0, 1'b1, 1, 3, 4'b1000, 1, "t1_ack0"};
    vecs[2]  = '{1'b0, 4'b1010, 1'b0, 1'b1, 1, 1, 4'b0010, 2, "t1_ack3"};
    vecs[3]  = '{1'b0, 4'b0010, 1'b0, 1'b1, 0, 0, 4'b0000, 3, "t1_ack1_idle"};
    vecs[4]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1, 3, 4'b1000, 0, "t2_first"};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 1, 2, 4'b0100, 1, "t2_rr2"};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 1, 1, 4'b0010, 2, "t2_rr1"};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 1, 0, 4'b0001, 3, "t2_rr0"};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 1, 3, 4'b1000, 4, "t2_rr_wrap"};
    vecs[9]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 1, 1, 4'b0010, 0, "t3_grant"};
    for (int i = 10; i < 15; i++) begin
      vecs[i] = '{1'b0, 4'b1010, 1'b0, 1'b0, 1, 1, 4'b0010, 0, "t3_hold"};
    end
    vecs[15] = '{1'b0, 4'b1010, 1'b0, 1'b1, 1, 3, 4'b1000, 1, "t3_ack"};
    vecs[16] = '{1'b0, 4'b0100, 1'b1, 1'b1, 1, 2, 4'b0100, 2, "t4_grant2"};
    vecs[17] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 4'b0000, 2, "t4_withdraw"};
    vecs[18] = '{1'b0, 4'b0100, 1'b1, 1'b0, 1, 2, 4'b0100, 2, "t4_regrant"};
    vecs[19] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1, 1, 4'b0010, 3, "t4_ptr_kept"};

    do_reset();
    check_zero("reset");

    // Directed table
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      req  = vecs[i].req;
      mode = vecs[i].mode;
      ack  = vecs[i].ack;
      tick();
      cmp({vecs[i].name, "_valid"}, int'(bus.valid), vecs[i].ev);
      cmp({vecs[i].name, "_onehot"}, int'(bus.gnt_onehot), vecs[i].eoh);
      cmp({vecs[i].name, "_cnt"}, int'(bus.gnt_cnt), vecs[i].ecnt);
      cmp({vecs[i].name, "_s_cnt"}, int'(bus_s.gnt_cnt),
          (vecs[i].ecnt > 3) ? 3 : vecs[i].ecnt);
      if (vecs[i].ev != 0) cmp({vecs[i].name, "_idx"}, int'(bus.gnt_idx), vecs[i].eidx);
    end

    // Asynchronous reset in the middle of a held grant
    do_reset();
    mode = 1'b1;
    req  = 4'b1111;
    tick();
    ack = 1'b1;
    repeat (5) tick();
    cmp("t5_pre_cnt", int'(bus.gnt_cnt), 5);
    cmp("t5_pre_valid", int'(bus.valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t5_async");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("t5_held");
    rst_n = 1'b1;
    ack   = 1'b0;
    tick();
    cmp("t5_first_valid", int'(bus.valid), 1);
    cmp("t5_first_idx", int'(bus.gnt_idx), 3);
    check_model("t5_model");

    // Saturation of the narrow counter while grants keep rotating
    ack = 1'b1;
    repeat (6) begin
      tick();
      check_model("t6_sat");
    end
    cmp("t6_s_cnt_sat", int'(bus_s.gnt_cnt), 3);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) req = N'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      ack = ($urandom_range(0, 2) == 0);
      tick();
      check_model("rand");
      cmp("rand_onehot_form", int'(bus.gnt_onehot),
          bus.valid ? (1 << bus.gnt_idx) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
